// File: rtl/mont_pkg.sv
// Shared constants for the Montgomery arithmetic datapath.
//   MODULUS : odd 256-bit field modulus M (secp256k1 base field).
//   M_PRIME : -M^-1 mod 2^64, derived from MODULUS at elaboration time.
//   DIGITS  : number of 64-bit reduction rounds, R = 2^(64*DIGITS).
//   state_e : control states of the REDC engine.
package mont_pkg;

  localparam int DIG_W  = 64;
  localparam int M_W    = 256;
  localparam int DIGITS = 4;
  localparam int ACC_W  = 513;
  localparam int QM_W   = DIG_W + M_W;
  localparam int RND_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [M_W-1:0] MODULUS =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  // Newton iteration for the inverse of an odd m modulo 2^64. x = m is
  // already correct to 3 bits (m*m == 1 mod 8); each step doubles the
  // number of correct bits, so five steps cover 64 bits.
  function automatic logic [DIG_W-1:0] neg_inv64(input logic [DIG_W-1:0] m);
    logic [DIG_W-1:0] x;
    x = m;
    for (int i = 0; i < 5; i++) begin
      x = x * (64'd2 - m * x);
    end
    return -x;
  endfunction

  localparam logic [DIG_W-1:0] M_PRIME = neg_inv64(MODULUS[DIG_W-1:0]);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIG  = 3'd1,
    MUL  = 3'd2,
    ACC  = 3'd3,
    FIN  = 3'd4,
    HOLD = 3'd5
  } state_e;

endpackage

// File: rtl/mont_qxm_64.sv
// Registered 64-bit digit times the constant modulus.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : capture q_i * MODULUS on this edge
//   q_i        : 64-bit quotient digit
//   qm_o       : 320-bit product, valid the cycle after en_i
module mont_qxm_64
  import mont_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIG_W-1:0] q_i,
  output logic [QM_W-1:0]  qm_o
);

  logic [QM_W-1:0] qm_d;
  logic [QM_W-1:0] qm_q;

  // Operands are widened to the full product width so no high bits are lost.
  always_comb qm_d = QM_W'(q_i) * QM_W'(MODULUS);

  // NOTE: non-blocking assignments for every flop so all registers update
  // together from pre-edge values. The product register is reset as well,
  // which keeps the output deterministic after an aborted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q <= '0;
    end else if (en_i) begin
      qm_q <= qm_d;
    end
  end

  assign qm_o = qm_q;

endmodule

// File: rtl/mont_redc_64.sv
// Word-serial Montgomery reduction: r_out = t_in * 2^-256 mod MODULUS.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, in_ready high only in IDLE
//   t_in                 : 512-bit product T, T < MODULUS * 2^256
//   out_valid / out_ready: result handshake, result held until accepted
//   r_out                : fully reduced result, always < MODULUS
//   busy                 : high from acceptance until the result is taken
module mont_redc_64
  import mont_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [511:0]   t_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M_W-1:0] r_out,
  output logic           busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(DIGITS - 1);

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [RND_W-1:0]  rnd_q;
  logic [DIG_W-1:0]  qd_q;
  logic [M_W-1:0]    r_out_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [QM_W-1:0]   qm;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_d;
  logic [DIG_W-1:0]  qd_d;
  logic [M_W-1:0]    r_fin_d;

  mont_qxm_64 u_qxm (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == MUL),
    .q_i   (qd_q),
    .qm_o  (qm)
  );

  // NOTE: every combinational output gets a value on every path (here via
  // an if/else with both arms) so no latch is inferred.
  always_comb begin
    // 513-bit sum keeps the carry out of acc + q*M.
    acc_sum = acc_q + ACC_W'(qm);
    acc_d   = acc_sum >> DIG_W;
    // Only the low 64 bits of the digit product are needed.
    qd_d    = acc_q[DIG_W-1:0] * M_PRIME;
    // acc < 2M after the last round, so one conditional subtraction fully
    // reduces; the 257th bit must take part in the compare.
    if (acc_q[M_W:0] >= {1'b0, MODULUS}) begin
      r_fin_d = acc_q[M_W-1:0] - MODULUS;
    end else begin
      r_fin_d = acc_q[M_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rnd_q       <= '0;
      qd_q        <= '0;
      r_out_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= {1'b0, t_in};
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= DIG;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DIG: begin
          qd_q    <= qd_d;
          state_q <= MUL;
        end
        MUL: begin
          // q*M is captured by the multiplier register on this edge.
          state_q <= ACC;
        end
        ACC: begin
          acc_q   <= acc_d;
          rnd_q   <= rnd_q + RND_W'(1);
          state_q <= (rnd_q == LAST_RND) ? FIN : DIG;
        end
        FIN: begin
          r_out_q     <= r_fin_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The digit choice guarantees the shifted-out word is zero.
  a_low_digit_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACC) |-> (acc_sum[DIG_W-1:0] == '0));

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r_out     = r_out_q;
  assign busy      = busy_q;

endmodule
